plotfour_move_ctrl: RTL

- Sequencing controller for the plot-four game datapath. It owns the two 42-square occupancy boards (blue = player one, red = player two).
- It arbitrates move requests from the two player keys and validates each move: range, occupancy, gravity support and turn order.
- After each write it runs a sequential win/draw scan, then updates round results and saturating scores.
- It sits between the synchronized key/switch inputs and the display logic (HEX, LEDR, VGA renderer).

---
 rtl/plotfour_pkg.sv | 9 +
 rtl/plotfour_if.sv | 26 ++
 rtl/plotfour_line_check.sv | 34 +++
 rtl/plotfour_move_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/plotfour_pkg.sv
// plotfour_pkg: shared sizes, state and player encodings for the plot-four controller.
package plotfour_pkg;
  localparam int ROWS_DEF = 7;
  localparam int COLS_DEF = 6;
  localparam int NSQ_DEF = ROWS_DEF * COLS_DEF;
  localparam int WIN_LEN = 4;
  typedef enum logic [2:0] {WAIT_MOVE, PLACE, CHECK, WIN, DRAW} state_t;
  typedef enum logic {P_ONE = 1'b0, P_TWO = 1'b1} player_t;
endpackage

// File: rtl/plotfour_if.sv
// plotfour_if: key/switch requests in, board/score/status out of the move controller.
interface plotfour_if #(parameter int NSQ = 42, parameter int SCORE_W = 4) ();
  logic start;
  logic new_round;
  logic p_one_req;
  logic p_two_req;
  logic [5:0] square;
  logic [NSQ-1:0] blue;
  logic [NSQ-1:0] red;
  logic turn;
  logic p_one_win;
  logic p_two_win;
  logic draw;
  logic [SCORE_W-1:0] p_one_score;
  logic [SCORE_W-1:0] p_two_score;
  logic move_err;
  logic busy;
  modport master (
    output start, new_round, p_one_req, p_two_req, square,
    input blue, red, turn, p_one_win, p_two_win, draw, p_one_score, p_two_score, move_err, busy
  );
  modport slave (
    input start, new_round, p_one_req, p_two_req, square,
    output blue, red, turn, p_one_win, p_two_win, draw, p_one_score, p_two_score, move_err, busy
  );
endinterface

// File: rtl/plotfour_line_check.sv
// plotfour_line_check: does a four-in-a-row line start at idx on this board.
module plotfour_line_check
  import plotfour_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [ROWS*COLS-1:0] board,
  input  logic [5:0]           idx,
  output logic                 hit
);
  logic [63:0] b;
  int row;
  int col;
  function automatic logic run(logic [63:0] v, int i, int step);
    logic ok;
    logic [63:0] s;
    ok = 1'b1;
    for (int k = 0; k < WIN_LEN; k++) begin
      s = v >> (i + k * step);
      ok = ok & s[0];
    end
    return ok;
  endfunction
  always_comb begin
    b = 64'(board);
    row = int'(idx) / COLS;
    col = int'(idx) % COLS;
    hit = (col <= COLS - WIN_LEN && run(b, int'(idx), 1)) ||
          (row <= ROWS - WIN_LEN && run(b, int'(idx), COLS)) ||
          (row <= ROWS - WIN_LEN && col <= COLS - WIN_LEN && run(b, int'(idx), COLS + 1)) ||
          (row <= ROWS - WIN_LEN && col >= WIN_LEN - 1 && run(b, int'(idx), COLS - 1));
  end
endmodule

// File: rtl/plotfour_move_ctrl.sv
// plotfour_move_ctrl: validates player moves, owns both boards, scans for win/draw and keeps scores.
module plotfour_move_ctrl
  import plotfour_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int SCORE_W = 4
) (
  input logic CLOCK_50,
  input logic reset,
  plotfour_if.slave io
);
  localparam int N = ROWS * COLS;
  localparam logic [6:0] N7 = 7'(N);
  localparam logic [5:0] C6 = 6'(COLS);
  localparam logic [5:0] LAST = 6'(N - 1);
  state_t state_q, state_d;
  player_t turn_q, turn_d, mover_q, mover_d;
  logic [N-1:0] blue_q, blue_d, red_q, red_d, occ, sel;
  logic [5:0] sq_q, sq_d, idx_q, idx_d;
  logic p1w_q, p1w_d, p2w_q, p2w_d, draw_q, draw_d, err_q, err_d;
  logic r1_q, r1_d, r2_q, r2_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [63:0] occ64;
  logic rise1, rise2, tr, oth, legal, hit;
  assign occ = blue_q | red_q;
  assign occ64 = 64'(occ);
  assign sel = {{(N-1){1'b0}}, 1'b1} << sq_q;
  assign rise1 = io.p_one_req & ~r1_q;
  assign rise2 = io.p_two_req & ~r2_q;
  assign tr = (turn_q == P_ONE) ? rise1 : rise2;
  assign oth = (turn_q == P_ONE) ? rise2 : rise1;
  assign legal = ({1'b0, io.square} < N7) && !occ64[io.square] &&
                 (io.square < C6 || occ64[io.square - C6]);
  assign r1_d = io.p_one_req;
  assign r2_d = io.p_two_req;
  plotfour_line_check #(.ROWS(ROWS), .COLS(COLS)) u_line (
    .board(mover_q == P_ONE ? blue_q : red_q),
    .idx(idx_q),
    .hit(hit)
  );
  always_comb begin
    state_d = state_q;
    blue_d = blue_q;
    red_d = red_q;
    turn_d = turn_q;
    mover_d = mover_q;
    sq_d = sq_q;
    idx_d = idx_q;
    p1w_d = p1w_q;
    p2w_d = p2w_q;
    draw_d = draw_q;
    s1_d = s1_q;
    s2_d = s2_q;
    err_d = 1'b0;
    case (state_q)
      WAIT_MOVE: if (io.start) begin
        err_d = oth || (tr && !legal);
        if (tr && legal) begin
          sq_d = io.square;
          mover_d = turn_q;
          state_d = PLACE;
        end
      end
      PLACE: begin
        blue_d = (mover_q == P_ONE) ? blue_q | sel : blue_q;
        red_d = (mover_q == P_TWO) ? red_q | sel : red_q;
        idx_d = '0;
        state_d = CHECK;
      end
      CHECK: if (hit) begin
        state_d = WIN;
        p1w_d = mover_q == P_ONE;
        p2w_d = mover_q == P_TWO;
        s1_d = (mover_q == P_ONE && !(&s1_q)) ? s1_q + SCORE_W'(1) : s1_q;
        s2_d = (mover_q == P_TWO && !(&s2_q)) ? s2_q + SCORE_W'(1) : s2_q;
      end else if (idx_q == LAST) begin
        state_d = (&occ) ? DRAW : WAIT_MOVE;
        draw_d = &occ;
        turn_d = (&occ) ? turn_q : (turn_q == P_ONE ? P_TWO : P_ONE);
      end else begin
        idx_d = idx_q + 6'd1;
      end
      default: ;
    endcase
    // a new round aborts any move in flight and discards its result, scores excepted
    if (io.new_round) begin
      state_d = WAIT_MOVE;
      blue_d = '0;
      red_d = '0;
      turn_d = P_ONE;
      p1w_d = 1'b0;
      p2w_d = 1'b0;
      draw_d = 1'b0;
      err_d = 1'b0;
      s1_d = s1_q;
      s2_d = s2_q;
    end
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_MOVE;
      blue_q <= '0;
      red_q <= '0;
      turn_q <= P_ONE;
      mover_q <= P_ONE;
      sq_q <= '0;
      idx_q <= '0;
      p1w_q <= 1'b0;
      p2w_q <= 1'b0;
      draw_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      err_q <= 1'b0;
      r1_q <= 1'b0;
      r2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blue_q <= blue_d;
      red_q <= red_d;
      turn_q <= turn_d;
      mover_q <= mover_d;
      sq_q <= sq_d;
      idx_q <= idx_d;
      p1w_q <= p1w_d;
      p2w_q <= p2w_d;
      draw_q <= draw_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      err_q <= err_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
    end
  end
  assign io.blue = blue_q;
  assign io.red = red_q;
  assign io.turn = turn_q;
  assign io.p_one_win = p1w_q;
  assign io.p_two_win = p2w_q;
  assign io.draw = draw_q;
  assign io.p_one_score = s1_q;
  assign io.p_two_score = s2_q;
  assign io.move_err = err_q;
  assign io.busy = (state_q == PLACE) || (state_q == CHECK);
endmodule
